aes_dec: RTL and testbench

AES_DEC -- requirements
Module: aes_dec

---
 rtl/aes_dec.sv | 140 ++++++++++++++
 tb/tb_aes_dec.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec.sv
// AES-128 iterative decryptor: one inverse round per clock, round keys fetched
// from an external key store by index (10 down to 0).
module aes_dec (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] cipher_text_i,
  output logic [3:0]   rnd_idx_o,
  input  logic [127:0] rnd_key_i,
  output logic [127:0] plain_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  // state | meaning
  // IDLE  | waiting for ciphertext, key 10 presented for the initial AddRoundKey
  // ROUND | one inverse round per clock, key rnd_cnt presented
  // DONE  | plaintext held on plain_o until downstream accepts
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rnd_cnt_q, rnd_cnt_d;
  logic [127:0] state_q, state_d;
  logic [127:0] sub_shift, ark, imc;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i sits at row i%4, column i/4; row r is rotated right by r.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = 4 * ((c - r + 4) % 4) + r;
        o[127-8*(4*c+r) -: 8] = INV_SBOX[s[127-8*src -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  assign sub_shift = inv_shift_sub(state_q);
  assign ark       = sub_shift ^ rnd_key_i;
  assign imc       = inv_mix(ark);
  assign plain_o   = state_q;

  always_comb begin
    fsm_d       = fsm_q;
    rnd_cnt_d   = rnd_cnt_q;
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    rnd_idx_o   = 4'd0;
    case (fsm_q)
      IDLE: begin
        in_ready_o = 1'b1;
        rnd_idx_o  = 4'd10;
        if (in_valid_i) begin
          state_d   = cipher_text_i ^ rnd_key_i;
          rnd_cnt_d = 4'd9;
          fsm_d     = ROUND;
        end
      end
      ROUND: begin
        rnd_idx_o = rnd_cnt_q;
        if (rnd_cnt_q != 4'd0) begin
          state_d   = imc;
          rnd_cnt_d = rnd_cnt_q - 4'd1;
        end else begin
          state_d = ark;
          fsm_d   = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fsm_q     <= IDLE;
      rnd_cnt_q <= 4'd0;
      state_q   <= '0;
    end else begin
      fsm_q     <= fsm_d;
      rnd_cnt_q <= rnd_cnt_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: tb/tb_aes_dec.sv
// Self-checking bench for aes_dec: FIPS-197 C.1, key-index sequence, backpressure,
// back-to-back throughput, mid-block reset and random blocks from a forward cipher.
module tb_aes_dec;

  logic         clk = 1'b0;
  logic         nrst;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] cipher_text_i;
  logic [3:0]   rnd_idx_o;
  logic [127:0] rnd_key_i;
  logic [127:0] plain_o;
  logic         out_valid_o;
  logic         out_ready_i;

  logic [127:0] rk [0:10];
  logic [127:0] key_noise;
  logic [7:0]   sbox_t [0:255];
  int           n_vec = 0;
  int           n_err = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  aes_dec dut (
    .clk(clk), .nrst(nrst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .cipher_text_i(cipher_text_i), .rnd_idx_o(rnd_idx_o), .rnd_key_i(rnd_key_i),
    .plain_o(plain_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
  );

  always #5 clk = ~clk;

  always_comb rnd_key_i = ((rnd_idx_o <= 4'd10) ? rk[rnd_idx_o] : 128'h0) ^ key_noise;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  // Forward S-box built from GF(2^8) inverse + affine map, independent of any table.
  task automatic init_sbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(b), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s, o;
    logic [7:0]   a0, a1, a2, a3;
    int           src;
    s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
      o = '0;
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) begin
          src = 4 * ((c + w) % 4) + w;
          o[127-8*(4*c+w) -: 8] = s[127-8*src -: 8];
        end
      s = o;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8];
          a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8];
          a3 = s[103-32*c -: 8];
          s[127-32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                               a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                               a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                               gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
        end
      end
      s = s ^ rk[r];
    end
    return s;
  endfunction

  // Present ct, follow the block to DONE, hold it for 'hold' cycles, then hand it off.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp_pt,
                           input int hold, input bit full, input string tag);
    int lat;
    @(negedge clk);
    in_valid_i    = 1'b1;
    cipher_text_i = ct;
    out_ready_i   = 1'b0;
    chk_eq({tag, "_rdy"}, in_ready_o, 1);
    if (full) chk_eq({tag, "_idx_idle"}, rnd_idx_o, 10);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid_i    = 1'b0;
      cipher_text_i = ~ct;
      lat++;
      if (full && lat <= 10) chk_eq({tag, "_idx_round"}, rnd_idx_o, 128'(10 - lat));
    end while (!out_valid_o && lat < 30);
    chk_eq({tag, "_latency"}, lat, 11);
    chk_eq({tag, "_plain"}, plain_o, exp_pt);
    if (full) chk_eq({tag, "_idx_done"}, rnd_idx_o, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid_i    = 1'b1;
      cipher_text_i = ~ct;
      key_noise     = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk_eq({tag, "_hold_plain"}, plain_o, exp_pt);
      chk_eq({tag, "_hold_valid"}, out_valid_o, 1);
      chk_eq({tag, "_hold_rdy"}, in_ready_o, 0);
    end
    in_valid_i  = 1'b0;
    key_noise   = '0;
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    chk_eq({tag, "_rel_valid"}, out_valid_o, 0);
    chk_eq({tag, "_rel_rdy"}, in_ready_o, 1);
  endtask

  initial begin
    int first, second, n_ov, cnt;
    logic [127:0] key, pt;
    nrst          = 1'b0;
    in_valid_i    = 1'b0;
    out_ready_i   = 1'b0;
    cipher_text_i = '0;
    key_noise     = '0;
    init_sbox();
    expand_key(C1_KEY);
    #1;
    chk_eq("rst_plain", plain_o, 0);
    chk_eq("rst_valid", out_valid_o, 0);
    chk_eq("rst_idx", rnd_idx_o, 10);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    #1;
    chk_eq("rst_rdy", in_ready_o, 1);

    run_block(C1_CT, C1_PT, 0, 1'b1, "c1");
    run_block(C1_CT, C1_PT, 5, 1'b0, "bp");
    run_block(C1_CT, C1_PT, 0, 1'b0, "after_bp");

    // Back-to-back with both handshakes held high: one output per block, 12 cycles apart.
    @(negedge clk);
    in_valid_i    = 1'b1;
    out_ready_i   = 1'b1;
    cipher_text_i = C1_CT;
    first = -1; second = -1; n_ov = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 13) in_valid_i = 1'b0;
      if (out_valid_o) begin
        n_ov++;
        chk_eq("b2b_plain", plain_o, C1_PT);
        if (first < 0) first = i; else second = i;
      end
    end
    out_ready_i = 1'b0;
    chk_eq("b2b_count", n_ov, 2);
    chk_eq("b2b_first", first, 11);
    chk_eq("b2b_gap", second - first, 12);

    // Reset in the middle of a block.
    @(negedge clk);
    in_valid_i    = 1'b1;
    cipher_text_i = C1_CT;
    @(negedge clk);
    in_valid_i = 1'b0;
    cnt = 0;
    while (rnd_idx_o != 4'd5 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk_eq("mid_reach5", rnd_idx_o, 5);
    #2 nrst = 1'b0;
    #1;
    chk_eq("mid_rst_plain", plain_o, 0);
    chk_eq("mid_rst_valid", out_valid_o, 0);
    chk_eq("mid_rst_idx", rnd_idx_o, 10);
    @(negedge clk);
    nrst = 1'b1;
    n_ov = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid_o) n_ov++;
    end
    chk_eq("mid_no_valid", n_ov, 0);
    chk_eq("mid_rdy", in_ready_o, 1);
    run_block(C1_CT, C1_PT, 0, 1'b1, "post_rst");

    for (int n = 0; n < 1000; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key);
      run_block(encrypt(pt), pt, 0, 1'b0, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
